// File: rtl/cl_axil_master_pkg.sv
// Shared types and constants for the single-outstanding AXI-Lite command master.
package cl_axil_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

  // States in which a bus transaction is in flight and the timeout budget is consumed.
  function automatic logic is_busy(input state_t s);
    return s inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  endfunction

endpackage

// File: rtl/cl_axil_master_timer.sv
// Per-transaction timeout down-counter: load at command acceptance, count busy cycles,
// flag expiry in the TIMEOUT_CYCLES-th busy cycle.
module cl_axil_master_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = W'(TIMEOUT_CYCLES - 1);
    else if (enable_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/cl_axil_master.sv
// Command-to-AXI-Lite master, one transaction outstanding, all outputs registered.
// Optional per-transaction timeout enabled by defining CL_AXIL_MASTER_TIMEOUT_EN.
module cl_axil_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_main_a0,
  input  logic        rst_main,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        m_awvalid,
  output logic [31:0] m_awaddr,
  output logic        m_wvalid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_bready,
  output logic        m_arvalid,
  output logic [31:0] m_araddr,
  output logic        m_rready,
  input  logic        m_awready,
  input  logic        m_wready,
  input  logic        m_bvalid,
  input  logic [1:0]  m_bresp,
  input  logic        m_arready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);
  import cl_axil_master_pkg::*;

  state_t      state_q;
  logic        cmd_ready_q, rsp_valid_q, timeout_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_resp_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        hs_done;
  logic        tmr_expired;

  // Completion condition of the current bus phase; a handshake here beats a same-cycle expiry.
  always_comb begin
    hs_done = 1'b0;
    unique case (state_q)
      WR_REQ:  hs_done = (!awvalid_q || m_awready) && (!wvalid_q || m_wready);
      WR_RESP: hs_done = m_bvalid;
      RD_REQ:  hs_done = m_arready;
      RD_RESP: hs_done = m_rvalid;
      default: hs_done = 1'b0;
    endcase
  end

`ifdef CL_AXIL_MASTER_TIMEOUT_EN
  logic tmr_load;
  assign tmr_load = (state_q == IDLE) && cmd_valid && cmd_ready_q;

  cl_axil_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_main_a0),
    .rst_i     (rst_main),
    .load_i    (tmr_load),
    .enable_i  (is_busy(state_q)),
    .expired_o (tmr_expired)
  );
`else
  // Constant 0 for every legal TIMEOUT_CYCLES: transactions wait indefinitely.
  assign tmr_expired = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      timeout_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else if (is_busy(state_q) && !hs_done && tmr_expired) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b1;
      rsp_resp_q  <= RESP_SLVERR;
      rsp_rdata_q <= TIMEOUT_RDATA;
      timeout_q   <= 1'b1;
      state_q     <= RSP;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Stray B/R beats are drained while idle.
          cmd_ready_q <= 1'b1;
          bready_q    <= 1'b1;
          rready_q    <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= cmd_addr;
            if (cmd_wr) begin
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (awvalid_q && m_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
          if (hs_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (hs_done) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= m_bresp;
            rsp_rdata_q <= '0;
            timeout_q   <= 1'b0;
            state_q     <= RSP;
          end
        end
        RD_REQ: begin
          if (hs_done) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (hs_done) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= m_rresp;
            rsp_rdata_q <= m_rdata;
            timeout_q   <= 1'b0;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            bready_q    <= 1'b1;
            rready_q    <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = timeout_q;
  assign m_awvalid   = awvalid_q;
  assign m_awaddr    = addr_q;
  assign m_wvalid    = wvalid_q;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign m_bready    = bready_q;
  assign m_arvalid   = arvalid_q;
  assign m_araddr    = addr_q;
  assign m_rready    = rready_q;

endmodule

// File: doc/cl_axil_master.md
CL_AXIL_MASTER -- requirements
Module: cl_axil_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 256, cycles allowed per transaction before forced completion (range 2..65535).
REQ-002 clk_main_a0  in  1  sole clock; all logic on its rising edge.
REQ-003 rst_main  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 cmd_wr  in  1  1 = write, 0 = read.
REQ-006 cmd_addr, cmd_wdata, cmd_wstrb  in  32/32/4  command payload (wdata and wstrb ignored for reads).
REQ-007 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-008 rsp_rdata, rsp_resp, rsp_timeout  out  32/2/1  read data (0 for writes), AXI resp code, timeout flag.
REQ-009 m_awvalid, m_awaddr[31:0], m_wvalid, m_wdata[31:0], m_wstrb[3:0], m_bready, m_arvalid, m_araddr[31:0], m_rready  out  AXI-Lite master outputs.
REQ-010 m_awready, m_wready, m_bvalid, m_bresp[1:0], m_arready, m_rvalid, m_rdata[31:0], m_rresp[1:0]  in  AXI-Lite master inputs.

Function
REQ-011 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-012 cmd_ready = 1 only in IDLE; on cmd_valid&&cmd_ready, payload is registered and FSM moves to WR_REQ (cmd_wr=1) or RD_REQ.
REQ-013 WR_REQ: m_awvalid and m_wvalid assert together the cycle after acceptance; each drops independently on its own handshake; exit to WR_RESP when both have completed (same or different cycles).
REQ-014 WR_RESP: m_bready=1; on m_bvalid capture m_bresp, rsp_rdata=0, go to RSP.
REQ-015 RD_REQ: m_arvalid=1 until m_arready, then RD_RESP; RD_RESP: m_rready=1, on m_rvalid capture m_rdata/m_rresp, go to RSP.
REQ-016 RSP: rsp_valid=1 with payload held stable until rsp_ready; then IDLE. Minimum command-to-rsp_valid latency 3 cycles with zero-wait slave.
REQ-017 Valid signals, once asserted, SHALL not drop or change payload before handshake (except REQ-022).
REQ-018 m_bready and m_rready SHALL also be 1 in IDLE, silently discarding stray beats.
REQ-019 One outstanding transaction only; no new command accepted until RSP handshake completes.
REQ-020 Address/data driven from registered payload; outputs are never combinational from cmd_* inputs.

Reset
REQ-021 When rst_main=1: FSM to IDLE; cmd_ready, rsp_valid, all m_*valid, m_bready, m_rready = 0; rsp_rdata, rsp_resp, rsp_timeout, m_*addr, m_wdata, m_wstrb = 0; timer = 0. Reset mid-transaction abandons it without response. After reset deasserts, cmd_ready=1 on the next cycle.

Configuration
REQ-022 Macro CL_AXIL_MASTER_TIMEOUT_EN defined: timer counts cycles in WR_REQ/WR_RESP/RD_REQ/RD_RESP; on reaching TIMEOUT_CYCLES, drop all m_*valid, go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=32'hDEAD_DEAD. Handshake in the same cycle as expiry wins (normal completion).
REQ-023 Macro not defined: no timer logic, rsp_timeout tied 0, transactions wait indefinitely.

Structure
REQ-024 Package cl_axil_master_pkg holds the FSM state enum, AXI resp constants (OKAY, SLVERR) and the timeout read-data constant 32'hDEAD_DEAD.
REQ-025 One sub-module cl_axil_master_timer (load/enable/expired, width from TIMEOUT_CYCLES), instantiated only under CL_AXIL_MASTER_TIMEOUT_EN.

Verification
REQ-026 Write addr 0x500, data 0x1234_5678, wstrb 0xF, zero-wait slave -> one AW and one W beat with those values, rsp_resp=0, rsp_rdata=0.
REQ-027 Write where slave accepts W 3 cycles before AW -> m_wvalid drops after its handshake, m_awvalid holds until accepted, exactly one B beat consumed.
REQ-028 Read addr 0x504, slave returns 0x0000_BEEF with rresp=2'b10 after 5-cycle wait -> rsp_rdata=0x0000_BEEF, rsp_resp=2'b10, rsp_valid held while rsp_ready=0 for 4 cycles.
REQ-029 With TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never raises arready -> m_arvalid drops after 16 cycles, rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0xDEAD_DEAD; next command then completes normally.
REQ-030 rst_main asserted in WR_RESP -> all outputs at reset values next cycle, no rsp_valid, late m_bvalid after reset discarded in IDLE.
REQ-031 Back-to-back commands with cmd_valid constantly high -> second accepted only the cycle after first RSP handshake.
